// File: rtl/drygascon128_seq_if.sv
// Host-side streams of the DryGASCON128 sequencer: command, input words, output words.
interface drygascon128_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_ds;
    logic [3:0]  cmd_rounds;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;

    modport master (
        output cmd_valid, cmd_op, cmd_ds, cmd_rounds, din_valid, din_data, dout_ready,
        input  cmd_ready, din_ready, dout_valid, dout_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ds, cmd_rounds, din_valid, din_data, dout_ready,
        output cmd_ready, din_ready, dout_valid, dout_data
    );
endinterface

// File: rtl/drygascon128_seq.sv
// Command sequencer for a DryGASCON128 core: streams words into C/X/I, starts the
// permutation with a watchdog, and streams R/C words back out.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a command (cmd_ready high)
// ST_WR    | moving input words into the core (C, X or I)
// ST_START | one-cycle core_start pulse
// ST_WAIT  | waiting for core_idle, watchdog running
// ST_RD    | moving R or C words out of the core
module drygascon128_seq #(
    parameter int WDOG_MAX = 255
) (
    input  logic                toplevel_io_mainClk,
    input  logic                toplevel_resetCtrl_systemReset_n,
    drygascon128_seq_if.slave   bus,
    output logic [31:0]         core_din,
    output logic                core_wr_c,
    output logic                core_wr_x,
    output logic                core_wr_i,
    output logic                core_rd_c,
    output logic                core_rd_r,
    output logic                core_start,
    output logic [3:0]          core_ds,
    output logic [3:0]          core_rounds,
    input  logic [31:0]         core_dout,
    input  logic                core_idle,
    output logic                busy,
    output logic                err
);
    localparam int WDOG_W = $clog2(WDOG_MAX + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD    = 3'd4;

    localparam logic [2:0] OP_LOAD_C = 3'd0;
    localparam logic [2:0] OP_LOAD_X = 3'd1;
    localparam logic [2:0] OP_ABSORB = 3'd2;
    localparam logic [2:0] OP_READ_R = 3'd3;
    localparam logic [2:0] OP_READ_C = 3'd4;

    logic              rst_n;
    logic [2:0]        state_q;
    logic [2:0]        op_q;
    logic [3:0]        cnt_q;
    logic [WDOG_W-1:0] wdog_q;
    logic              cmd_fire;
    logic              cmd_bad;
    logic              cmd_is_rd;
    logic              din_fire;
    logic              dout_fire;
    logic              wdog_hit;

    function automatic logic [3:0] last_index(input logic [2:0] op);
        case (op)
            OP_LOAD_C, OP_READ_C: return 4'd9;
            default:              return 4'd3;
        endcase
    endfunction

    assign rst_n     = toplevel_resetCtrl_systemReset_n;
    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign cmd_bad   = (bus.cmd_op > OP_READ_C) ||
                       ((bus.cmd_op == OP_ABSORB) && (bus.cmd_rounds == 4'd0));
    assign cmd_is_rd = (bus.cmd_op == OP_READ_R) || (bus.cmd_op == OP_READ_C);

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.din_ready  = (state_q == ST_WR);
    assign bus.dout_valid = (state_q == ST_RD);
    assign bus.dout_data  = core_dout;
    assign core_din       = bus.din_data;
    assign busy           = (state_q != ST_IDLE);

    // Strobes are gated by reset so an abandoned transfer never touches the core.
    assign din_fire   = bus.din_ready && bus.din_valid && rst_n;
    assign dout_fire  = bus.dout_valid && bus.dout_ready && rst_n;
    assign core_wr_c  = din_fire && (op_q == OP_LOAD_C);
    assign core_wr_x  = din_fire && (op_q == OP_LOAD_X);
    assign core_wr_i  = din_fire && (op_q == OP_ABSORB);
    assign core_rd_r  = dout_fire && (op_q == OP_READ_R);
    assign core_rd_c  = dout_fire && (op_q == OP_READ_C);
    assign core_start = (state_q == ST_START) && rst_n;

    // Watchdog counts WAIT cycles from 0; the cycle holding WDOG_MAX-1 is the last one.
    assign wdog_hit = (wdog_q == WDOG_W'(WDOG_MAX - 1));

    always_ff @(posedge toplevel_io_mainClk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD_C;
            cnt_q       <= 4'd0;
            wdog_q      <= '0;
            core_ds     <= 4'd0;
            core_rounds <= 4'd11;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            op_q    <= bus.cmd_op;
                            cnt_q   <= last_index(bus.cmd_op);
                            state_q <= cmd_is_rd ? ST_RD : ST_WR;
                            if (bus.cmd_op == OP_ABSORB) begin
                                core_ds     <= bus.cmd_ds;
                                core_rounds <= bus.cmd_rounds;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (din_fire) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= (op_q == OP_ABSORB) ? ST_START : ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    wdog_q  <= '0;
                end
                ST_WAIT: begin
                    // core_idle may still show the pre-start value in the first WAIT cycle.
                    if ((wdog_q != '0) && core_idle) begin
                        state_q <= ST_IDLE;
                    end else if (wdog_hit) begin
                        state_q <= ST_IDLE;
                        err     <= 1'b1;
                    end
                    wdog_q <= wdog_q + WDOG_W'(1);
                end
                ST_RD: begin
                    if (dout_fire) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drygascon128_seq.sv
// Self-checking bench for drygascon128_seq: command table, directed corner cases, random commands.
`timescale 1ns/1ps
module tb_drygascon128_seq;
    localparam int WDOG_MAX = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    drygascon128_seq_if bus();

    logic [31:0] core_din;
    logic        core_wr_c, core_wr_x, core_wr_i, core_rd_c, core_rd_r, core_start;
    logic [3:0]  core_ds, core_rounds;
    logic [31:0] core_dout;
    logic        core_idle;
    logic        busy, err;

    drygascon128_seq #(.WDOG_MAX(WDOG_MAX)) dut (
        .toplevel_io_mainClk             (clk),
        .toplevel_resetCtrl_systemReset_n(rst_n),
        .bus                             (bus),
        .core_din                        (core_din),
        .core_wr_c                       (core_wr_c),
        .core_wr_x                       (core_wr_x),
        .core_wr_i                       (core_wr_i),
        .core_rd_c                       (core_rd_c),
        .core_rd_r                       (core_rd_r),
        .core_start                      (core_start),
        .core_ds                         (core_ds),
        .core_rounds                     (core_rounds),
        .core_dout                       (core_dout),
        .core_idle                       (core_idle),
        .busy                            (busy),
        .err                             (err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_err = 0, n_start = 0, n_rd_r = 0, n_rd_c = 0;
    int start_cyc = -1, err_cyc = -1, busy_fall_cyc = -1;
    int last_wr_cyc = -1, first_strobe_cyc = -1, accept_cyc = -1;
    bit busy_seen = 0, last_busy = 0, stuck = 0;
    int idle_len = 3;
    int idle_cnt = 0;
    logic [35:0] got_wr[$];
    logic [35:0] exp_wr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        core_dout = $urandom;
    end

    // Passive monitor plus a tiny core model: core_idle drops for idle_len WAIT cycles after a start.
    always @(negedge clk) begin
        int ns;
        ns = $countones({core_wr_c, core_wr_x, core_wr_i, core_rd_c, core_rd_r, core_start});
        if (ns != 0) chk("strobe_onehot", ns, 1);
        if (core_wr_c) got_wr.push_back({4'd1, core_din});
        if (core_wr_x) got_wr.push_back({4'd2, core_din});
        if (core_wr_i) got_wr.push_back({4'd3, core_din});
        if (core_wr_c || core_wr_x || core_wr_i || core_rd_r || core_rd_c) begin
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
        end
        if (core_wr_c || core_wr_x || core_wr_i) last_wr_cyc = cyc;
        if (core_rd_r || core_rd_c) chk("rd_data", bus.dout_data, core_dout);
        if (core_rd_r) n_rd_r++;
        if (core_rd_c) n_rd_c++;
        if (core_start) begin
            n_start++;
            start_cyc = cyc;
            idle_cnt = idle_len + 1;
        end else if (idle_cnt > 0) begin
            idle_cnt--;
        end
        core_idle = !stuck && (idle_cnt == 0);
        if (err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        if (last_busy && !busy) busy_fall_cyc = cyc;
        last_busy = busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] ds, input logic [3:0] rounds);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_ds = ds;
        bus.cmd_rounds = rounds;
        @(negedge clk);
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept", bus.cmd_ready, 1);
        accept_cyc = cyc;
        first_strobe_cyc = -1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random
    task automatic feed(input int n, input int mode, input logic [3:0] kind);
        int sent = 0;
        int c = 0;
        bit v;
        while (sent < n && c < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.din_valid = v;
            bus.din_data = $urandom;
            @(negedge clk);
            if (bus.din_valid && bus.din_ready) begin
                exp_wr.push_back({kind, bus.din_data});
                sent++;
            end
            step();
            c++;
        end
        chk("wr_words_taken", sent, n);
        bus.din_valid = 1'b1;
        bus.din_data = $urandom;
        repeat (2) step();
        bus.din_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: stalled for 5 cycles then ready, 2: random
    task automatic drain(input int n, input int mode);
        int got = 0;
        int c = 0;
        while (got < n && c < 400) begin
            case (mode)
                0:       bus.dout_ready = 1'b1;
                1:       bus.dout_ready = (c >= 5);
                default: bus.dout_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (bus.dout_valid && bus.dout_ready) got++;
            step();
            c++;
        end
        chk("rd_words_taken", got, n);
        bus.dout_ready = 1'b1;
        repeat (2) step();
        bus.dout_ready = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        @(negedge clk);
        while (busy && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", busy, 0);
        step();
    endtask

    // kind: 0 none/illegal, 1 wr_c, 2 wr_x, 3 wr_i, 4 rd_r, 5 rd_c
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] ds, input logic [3:0] rounds,
                          input int mode, input int exp_n, input logic [3:0] kind, input int exp_err,
                          input logic [3:0] exp_ds, input logic [3:0] exp_rounds);
        int e0 = n_err;
        int s0 = n_start;
        int r0 = n_rd_r;
        int c0 = n_rd_c;
        int nw;
        got_wr.delete();
        exp_wr.delete();
        issue(op, ds, rounds);
        if (kind >= 4'd1 && kind <= 4'd3) feed(exp_n, mode, kind);
        else if (kind >= 4'd4) drain(exp_n, mode);
        wait_idle(WDOG_MAX + 50);
        step();
        nw = (kind >= 4'd1 && kind <= 4'd3) ? exp_n : 0;
        chk("err_pulses", n_err - e0, exp_err);
        chk("start_pulses", n_start - s0, (kind == 4'd3) ? 1 : 0);
        chk("rd_r_pulses", n_rd_r - r0, (kind == 4'd4) ? exp_n : 0);
        chk("rd_c_pulses", n_rd_c - c0, (kind == 4'd5) ? exp_n : 0);
        chk("wr_count", got_wr.size(), nw);
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            chk("wr_word", got_wr[i], exp_wr[i]);
        chk("core_ds", core_ds, exp_ds);
        chk("core_rounds", core_rounds, exp_rounds);
        chk("busy_end", busy, 0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] ds;
        logic [3:0] rounds;
        int         n;
        logic [3:0] kind;
        int         err;
        logic [3:0] exp_ds;
        logic [3:0] exp_rounds;
    } vec_t;

    vec_t vecs[9];
    int counts[8] = '{10, 4, 4, 4, 10, 0, 0, 0};

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [2:0] op;
        logic [3:0] ds, rounds, kind, m_ds, m_rounds;
        bit bad;

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_ds = 4'd0; bus.cmd_rounds = 4'd0;
        bus.din_valid = 1'b0; bus.din_data = 32'd0; bus.dout_ready = 1'b0;
        core_dout = 32'd0;
        core_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_err", err, 0);
        chk("rst_core_ds", core_ds, 0);
        chk("rst_core_rounds", core_rounds, 11);
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        step();

        // LOAD_C with din_valid toggling
        do_cmd(3'd0, 4'd0, 4'd0, 1, 10, 4'd1, 0, 4'd0, 4'd11);
        chk("loadc_first_wr_lat", first_strobe_cyc - accept_cyc, 1);
        chk("loadc_cmd_ready", bus.cmd_ready, 1);

        // ABSORB ds=3 rounds=7, core busy for 7 cycles
        idle_len = 7;
        do_cmd(3'd2, 4'd3, 4'd7, 0, 4, 4'd3, 0, 4'd3, 4'd7);
        chk("absorb_start_lat", start_cyc - last_wr_cyc, 1);
        chk("absorb_idle_exit", busy_fall_cyc - start_cyc, 9);

        // READ_R stalled 5 cycles
        do_cmd(3'd3, 4'd0, 4'd0, 1, 4, 4'd4, 0, 4'd3, 4'd7);
        chk("readr_stall_lat", first_strobe_cyc - accept_cyc, 6);

        // illegal opcode and ABSORB with zero rounds
        busy_seen = 0;
        do_cmd(3'd6, 4'd0, 4'd0, 0, 0, 4'd0, 1, 4'd3, 4'd7);
        chk("illegal_err_lat", err_cyc - accept_cyc, 1);
        do_cmd(3'd2, 4'd9, 4'd0, 0, 0, 4'd0, 1, 4'd3, 4'd7);
        chk("illegal_busy", busy_seen, 0);

        // watchdog timeout with core_idle stuck low
        stuck = 1;
        do_cmd(3'd2, 4'd1, 4'd5, 0, 4, 4'd3, 1, 4'd1, 4'd5);
        chk("wdog_err_time", err_cyc - start_cyc, WDOG_MAX + 1);
        chk("wdog_idle_time", busy_fall_cyc, err_cyc);
        stuck = 0;
        step();

        // reset after the 2nd LOAD_X word
        got_wr.delete();
        exp_wr.delete();
        issue(3'd1, 4'd0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            bus.din_valid = 1'b1;
            bus.din_data = $urandom;
            @(negedge clk);
            if (bus.din_ready) exp_wr.push_back({4'd2, bus.din_data});
            step();
        end
        bus.din_data = $urandom;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
        step();
        bus.din_valid = 1'b0;
        chk("rst_mid_wr_count", got_wr.size(), 2);
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            chk("rst_mid_wr_word", got_wr[i], exp_wr[i]);
        do_cmd(3'd1, 4'd0, 4'd0, 0, 4, 4'd2, 0, 4'd0, 4'd11);

        // command table, starting from post-reset config
        vecs[0] = '{3'd0, 4'd0,  4'd0,  10, 4'd1, 0, 4'd0,  4'd11};
        vecs[1] = '{3'd1, 4'd4,  4'd4,  4,  4'd2, 0, 4'd0,  4'd11};
        vecs[2] = '{3'd2, 4'd5,  4'd9,  4,  4'd3, 0, 4'd5,  4'd9};
        vecs[3] = '{3'd3, 4'd1,  4'd1,  4,  4'd4, 0, 4'd5,  4'd9};
        vecs[4] = '{3'd4, 4'd2,  4'd2,  10, 4'd5, 0, 4'd5,  4'd9};
        vecs[5] = '{3'd7, 4'd6,  4'd6,  0,  4'd0, 1, 4'd5,  4'd9};
        vecs[6] = '{3'd2, 4'd2,  4'd0,  0,  4'd0, 1, 4'd5,  4'd9};
        vecs[7] = '{3'd5, 4'd0,  4'd3,  0,  4'd0, 1, 4'd5,  4'd9};
        vecs[8] = '{3'd2, 4'd15, 4'd15, 4,  4'd3, 0, 4'd15, 4'd15};
        for (int i = 0; i < 9; i++) begin
            idle_len = $urandom_range(1, 10);
            do_cmd(vecs[i].op, vecs[i].ds, vecs[i].rounds, 2, vecs[i].n, vecs[i].kind,
                   vecs[i].err, vecs[i].exp_ds, vecs[i].exp_rounds);
        end

        // random commands against a transaction-level model
        m_ds = vecs[8].exp_ds;
        m_rounds = vecs[8].exp_rounds;
        for (int i = 0; i < 25; i++) begin
            op = 3'($urandom_range(0, 7));
            ds = 4'($urandom_range(0, 15));
            rounds = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            bad = (op > 3'd4) || (op == 3'd2 && rounds == 4'd0);
            if (!bad && op == 3'd2) begin
                m_ds = ds;
                m_rounds = rounds;
            end
            kind = bad ? 4'd0 : 4'(op) + 4'd1;
            idle_len = $urandom_range(1, 15);
            do_cmd(op, ds, rounds, 2, bad ? 0 : counts[op], kind, bad ? 1 : 0, m_ds, m_rounds);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/drygascon128_seq.md
DRYGASCON128_SEQ -- requirements
Module: drygascon128_seq

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 255, meaning max cycles waited for core_idle after start before timeout.
REQ-002 SHALL have ports (clock and reset first):
- toplevel_io_mainClk, in, 1: sole clock; all state on rising edge.
- toplevel_resetCtrl_systemReset_n, in, 1: synchronous, active-low reset.
- cmd_valid/cmd_ready, in/out, 1/1: command handshake.
- cmd_op, in, 3: 0 LOAD_C, 1 LOAD_X, 2 ABSORB, 3 READ_R, 4 READ_C; 5-7 illegal.
- cmd_ds, in, 4: domain separator for ABSORB.
- cmd_rounds, in, 4: round count for ABSORB.
- din_valid/din_ready/din_data, in/out/in, 1/1/32: input word stream.
- dout_valid/dout_ready/dout_data, out/in/out, 1/1/32: output word stream.
- core_din, out, 32: word to core.
- core_wr_c/core_wr_x/core_wr_i, out, 1 each: core write strobes.
- core_rd_c/core_rd_r, out, 1 each: core read strobes.
- core_start, out, 1: one-cycle start pulse.
- core_ds/core_rounds, out, 4/4: registered config to core.
- core_dout/core_idle, in, 32/1: core read data (valid same cycle as rd strobe) and idle flag.
- busy, out, 1: high in any state except IDLE.
- err, out, 1: one-cycle pulse on illegal command or watchdog timeout.

Function
REQ-003 SHALL implement states IDLE, WR, START, WAIT, RD.
REQ-004 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on cmd_valid&cmd_ready.
REQ-005 Word counts SHALL be: LOAD_C 10, LOAD_X 4, ABSORB 4, READ_R 4, READ_C 10; a 4-bit counter is loaded with count-1 on acceptance.
REQ-006 Illegal opcode (5-7) or ABSORB with cmd_rounds==0 SHALL be consumed, pulse err in the next cycle, and stay in IDLE.
REQ-007 LOAD_C/LOAD_X/ABSORB SHALL go IDLE->WR; READ_R/READ_C SHALL go IDLE->RD.
REQ-008 In WR, din_ready SHALL be 1; core_din = din_data combinationally; on din_valid the matching strobe (wr_c/wr_x/wr_i) is 1 that cycle, else 0; the counter decrements per transferred word.
REQ-009 After the last WR word: LOAD_C/LOAD_X -> IDLE; ABSORB -> START.
REQ-010 On ABSORB acceptance, core_ds/core_rounds SHALL latch cmd_ds/cmd_rounds; they hold otherwise.
REQ-011 START SHALL last exactly one cycle with core_start=1, then -> WAIT with watchdog cleared.
REQ-012 WAIT SHALL ignore core_idle in its first cycle; from the second cycle, core_idle=1 -> IDLE.
REQ-013 Watchdog SHALL increment each WAIT cycle; on reaching WDOG_MAX with core_idle=0 -> IDLE with err pulse.
REQ-014 In RD, dout_valid SHALL be 1 and dout_data = core_dout; strobe (rd_r/rd_c) is 1 only in cycles with dout_ready=1; the counter decrements per transfer; the last transfer -> IDLE.
REQ-015 din_ready SHALL be 0 outside WR; dout_valid SHALL be 0 outside RD.
REQ-016 At most one of core_wr_c, core_wr_x, core_wr_i, core_rd_c, core_rd_r, core_start SHALL be 1 in any cycle.
REQ-017 Stalls (din_valid=0 or dout_ready=0) SHALL hold state and counter indefinitely, with no timeout.
REQ-018 Latency SHALL be: accept -> first strobe possible in the next cycle; last WR word -> core_start in the next cycle.

Reset
REQ-019 Reset SHALL set: state IDLE, counter 0, watchdog 0, core_ds 0, core_rounds 11, all strobes 0, err 0, busy 0, cmd_ready 1 in the first cycle after release.
REQ-020 Reset asserted mid-transfer or mid-WAIT SHALL abandon the operation with no strobe in the reset cycle; partial data is not resumed.

Verification
- LOAD_C with 10 words, din_valid toggling every other cycle -> exactly 10 core_wr_c pulses in input order, then cmd_ready=1.
- ABSORB ds=3, rounds=7 with 4 words, core_idle dropping for 7 cycles -> 4 wr_i, one core_start, core_ds=3, core_rounds=7, returns to IDLE after idle.
- READ_R with dout_ready=0 for 5 cycles, then 1 -> no rd_r while stalled, 4 words equal to core_dout, 4 rd_r pulses.
- cmd_op=6, then ABSORB with rounds=0 -> two err pulses, no core strobes, busy stays 0.
- ABSORB with core_idle stuck at 0 and WDOG_MAX=255 -> err pulse 255 cycles after entering WAIT, then IDLE.
- Reset after the 2nd word of LOAD_X -> no further wr_x, busy=0, and a new LOAD_X takes 4 fresh words.
